// File: rtl/prime_pkg.sv
// Shared definitions for the prime_test primality tester and its divider.
package prime_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int FIRST_DIV = 2;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_ACK,
    WAIT_RES,
    DONE
  } state_t;

endpackage

// File: rtl/prime_test_divrem.sv
// divrem: iterative restoring divider, one quotient bit per cycle.
// ready drops the cycle after an accepted go and rises again with quot/rem/error
// valid; those results hold until the next accepted go. den==0 flags error.
module divrem #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic [WIDTH-1:0] num,
  input  logic [WIDTH-1:0] den,
  output logic             ready,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem,
  output logic             error
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] den_r;
  logic [WIDTH:0]   r_sh;
  logic [WIDTH-1:0] r_sub;
  logic             fits;

  // Shift the next dividend bit into the partial remainder and trial-subtract.
  always_comb begin
    r_sh  = {rem, quot[WIDTH-1]};
    fits  = (r_sh >= {1'b0, den_r});
    r_sub = r_sh[WIDTH-1:0] - den_r;
  end

  // Accept a new operation when idle, otherwise run one restoring step per cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready <= 1'b1;
      quot  <= '0;
      rem   <= '0;
      error <= 1'b0;
      den_r <= '0;
      cnt   <= '0;
    end else if (ready) begin
      if (go) begin
        ready <= 1'b0;
        quot  <= num;
        rem   <= '0;
        den_r <= den;
        error <= (den == '0);
        cnt   <= CW'(WIDTH);
      end
    end else begin
      quot <= {quot[WIDTH-2:0], fits};
      rem  <= fits ? r_sub : r_sh[WIDTH-1:0];
      cnt  <= cnt - CW'(1);
      if (cnt == CW'(1)) begin
        ready <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/prime_test.sv
// prime_test: trial-division primality tester driving an internal divrem.
// Divisors run 2,3,4,... ; the walk stops on a zero remainder (composite) or
// when quot < d, which proves d*d > n without a multiplier (prime).
// Optional build macro PRIME_TEST_ODD_DIV_EN: after d=2 only odd divisors
// 3,5,7,... are tried. Results are identical; only ndiv and latency change.
//
// state    | meaning
// IDLE     | ready=1, results valid, waiting for go
// ISSUE    | launch one divrem op with (n, d), count it
// WAIT_ACK | wait for divrem to drop its stale ready
// WAIT_RES | wait for divrem result and decide
// DONE     | publish ready for one cycle, then back to IDLE
module prime_test
  import prime_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic [WIDTH-1:0] num,
  output logic             ready,
  output logic             is_prime,
  output logic             error,
  output logic [WIDTH-1:0] ndiv
);

  state_t           state;
  logic [WIDTH-1:0] n;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] d_next;
  logic [WIDTH-1:0] cnt;
  logic             div_go;
  logic             div_ready;
  logic [WIDTH-1:0] div_quot;
  logic [WIDTH-1:0] div_rem;
  logic             div_err;

  divrem #(.WIDTH(WIDTH)) u_divrem (
    .clk   (clk),
    .rst   (rst),
    .go    (div_go),
    .num   (n),
    .den   (d),
    .ready (div_ready),
    .quot  (div_quot),
    .rem   (div_rem),
    .error (div_err)
  );

  // Next trial divisor.
  always_comb begin
`ifdef PRIME_TEST_ODD_DIV_EN
    d_next = (d == WIDTH'(FIRST_DIV)) ? d + WIDTH'(1) : d + WIDTH'(2);
`else
    d_next = d + WIDTH'(1);
`endif
  end

  // Sequencing FSM with registered result outputs; the op count is kept
  // privately and only published on entry to DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ready    <= 1'b1;
      is_prime <= 1'b0;
      error    <= 1'b0;
      ndiv     <= '0;
      n        <= '0;
      d        <= WIDTH'(FIRST_DIV);
      cnt      <= '0;
      div_go   <= 1'b0;
    end else begin
      div_go <= 1'b0;
      case (state)
        IDLE: begin
          if (go) begin
            n     <= num;
            error <= 1'b0;
            ndiv  <= '0;
            cnt   <= '0;
            ready <= 1'b0;
            d     <= WIDTH'(FIRST_DIV);
            if (num < WIDTH'(2)) begin
              is_prime <= 1'b0;
              state    <= DONE;
            end else if (num < WIDTH'(4)) begin
              is_prime <= 1'b1;
              state    <= DONE;
            end else begin
              state <= ISSUE;
            end
          end
        end
        ISSUE: begin
          div_go <= 1'b1;
          cnt    <= cnt + WIDTH'(1);
          state  <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (!div_ready) begin
            state <= WAIT_RES;
          end
        end
        WAIT_RES: begin
          if (div_ready) begin
            if (div_err) begin
              error    <= 1'b1;
              is_prime <= 1'b0;
              ndiv     <= cnt;
              state    <= DONE;
            end else if (div_rem == '0) begin
              is_prime <= 1'b0;
              ndiv     <= cnt;
              state    <= DONE;
            end else if (div_quot < d) begin
              is_prime <= 1'b1;
              ndiv     <= cnt;
              state    <= DONE;
            end else begin
              d     <= d_next;
              state <= ISSUE;
            end
          end
        end
        DONE: begin
          ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef SYNTHESIS
  a_d_nonzero: assert property (@(posedge clk) disable iff (rst) d != '0);
`endif

endmodule

// File: doc/prime_test.md
Name: prime_test

Overview:
- Primality tester for one unsigned candidate; it sits directly upstream of divrem and drives it.
- It walks trial divisors d = 2, 3, 4, … and issues one divrem operation per divisor.
- It stops at the first zero remainder (composite) or when quot < d (prime).
- It uses no multiplier: the d*d > num test comes free from the divrem quotient.

Parameters:
- WIDTH, 16, bit width of candidate, divisor, quotient and remainder.

Ports:
- clk  in  1  system clock, all flops on posedge
- rst  in  1  asynchronous active-high reset
- go  in  1  start strobe; sampled only when ready=1
- num  in  WIDTH  candidate, captured on accepted go
- ready  out  1  high = idle, result outputs valid
- is_prime  out  1  result: 1 = num is prime
- error  out  1  divrem reported error during run
- ndiv  out  WIDTH  number of divrem operations used for last result

Behaviour:
- Reset values (asynchronous): ready=1, is_prime=0, error=0, ndiv=0, state IDLE, divisor reg=2, div_go=0.
- Contract for internal divrem (inputs clk, rst, go, num, den):
  - It samples go on posedge.
  - ready deasserts no later than the cycle after go is sampled.
  - ready reasserts with quot/rem/error valid and holds until the next go.
- States:
  - IDLE: ready=1.
    - On go: latch num into n and clear error/ndiv; ready=0 from next cycle.
    - If n<2: is_prime=0, go to DONE.
    - If n is 2 or 3: is_prime=1, go to DONE.
    - Otherwise: d=2, go to ISSUE.
  - ISSUE: assert div_go for exactly one cycle with div_num=n, div_den=d; ndiv++; go to WAIT_ACK.
  - WAIT_ACK: wait for divrem ready=0. This guards against a stale ready, which remains high until divrem starts the new operation; go to WAIT_RES.
  - WAIT_RES: wait for divrem ready=1, then evaluate in that cycle:
    - divrem error=1: error=1, is_prime=0, DONE.
    - rem==0: is_prime=0, DONE.
    - quot<d: is_prime=1, DONE (d*d>n proven).
    - Otherwise: d=d+1, ISSUE.
  - DONE: ready=1, outputs frozen; go to IDLE in the same cycle. DONE is a one-cycle alias of IDLE for the ready rise.
- Result outputs update only on entry to DONE. They hold until the next accepted go.
- go while ready=0 is ignored; num changes while busy are ignored.
- d never exceeds sqrt(2^WIDTH)+1, so the divisor cannot wrap. Assert in simulation that d never reaches 0.
- rst mid-run: all state returns to reset values immediately. The internal divrem is reset by the same rst.
- Latency for n<4: ready returns 2 cycles after go. Otherwise ready returns after ndiv × (divrem latency + 3) cycles.

Optional Feature:
- PRIME_TEST_ODD_DIV_EN
  - Defined: after d=2 the divisor sequence is 3, 5, 7, … (d+=2), which halves the iterations.
  - Undefined: d+=1 every step.
- Results are identical either way; only ndiv and latency differ.

Decomposition:
- Shared package prime_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT_ACK, WAIT_RES, DONE);
  - a WIDTH default constant;
  - the constant FIRST_DIV=2.
- One sub-module instance: divrem, instantiated internally and wired to clk/rst.
- No other hierarchy.

Test Plan:
- num=0, 1 → is_prime=0, error=0, ndiv=0, ready back 2 cycles after go. num=2, 3 → is_prime=1, ndiv=0.
- num=97 → is_prime=1. ndiv=9 (d=2..10), or ndiv=6 with PRIME_TEST_ODD_DIV_EN (d=2,3,5,7,9,11). num=91 → is_prime=0, ndiv=6 (d=2..7), or 4 with the macro.
- num=65521 → is_prime=1. num=65535 → is_prime=0 at d=3 (ndiv=2).
- go pulsed with num=4 while busy on num=97 → ignored; result is for 97. Next go with num=4 → is_prime=0, ndiv=1.
- rst asserted in WAIT_RES during num=97 → ready=1, is_prime=0, ndiv=0 immediately. A fresh go with num=13 → is_prime=1.
- Sweep num=0..500 against a behavioural trial-division model. Check is_prime, error=0, no X on outputs once ready, and no acceptance of go while busy.
